// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with 16-bit register pointer and byte storage.
// SCL/SDA are oversampled on clk (2-flop sync + stability filter). The same
// memory is exposed to the fabric through a simple local read/write port.
module i2c_target_regs #(
  parameter int MEM_SIZE   = 256,
  parameter int FILTER_LEN = 4,
  parameter int SDA_HOLD   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  dev_addr,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [15:0] host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int FCW    = $clog2(FILTER_LEN + 1);
  localparam int HCW    = $clog2(SDA_HOLD + 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DEV_ADDR    = 4'd1,
    DEV_ACK     = 4'd2,
    ADDR_HI     = 4'd3,
    ADDR_HI_ACK = 4'd4,
    ADDR_LO     = 4'd5,
    ADDR_LO_ACK = 4'd6,
    WR_DATA     = 4'd7,
    WR_ACK      = 4'd8,
    RD_DATA     = 4'd9,
    RD_ACK      = 4'd10,
    IGNORE      = 4'd11
  } state_e;

  // Storage: contents deliberately have no reset.
  logic [7:0] mem_q [MEM_SIZE];

  // Input conditioning
  logic [1:0]     scl_sync_q, scl_sync_d;
  logic [1:0]     sda_sync_q, sda_sync_d;
  logic           scl_filt_q, scl_filt_d;
  logic           sda_filt_q, sda_filt_d;
  logic [FCW-1:0] scl_cnt_q, scl_cnt_d;
  logic [FCW-1:0] sda_cnt_q, sda_cnt_d;
  logic           scl_prev_q, sda_prev_q;
  logic           sda_in_s;
  logic           scl_rise_s, scl_fall_s, start_s, stop_s;

  // Protocol state
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    ptr_q, ptr_d;
  logic [7:0]     tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           sda_low_q, sda_low_d;
  logic           hold_act_q, hold_act_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           sda_update_s;
  logic           wr_strobe_q, wr_strobe_d;
  logic [15:0]    wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     host_rdata_q;

  logic [7:0]        byte_s;
  logic              i2c_we_s;
  logic [15:0]       ptr_inc_s;
  logic [MEM_AW-1:0] ptr_idx_s, ptr_inc_idx_s, host_idx_s;
  logic              unused_host_hi_s;

  assign sda_in_s      = i2c_sda;
  assign i2c_sda       = sda_low_q ? 1'b0 : 1'bz;

  assign scl_sync_d    = {scl_sync_q[0], i2c_scl};
  assign sda_sync_d    = {sda_sync_q[0], sda_in_s};

  assign scl_rise_s    =  scl_filt_q & ~scl_prev_q;
  assign scl_fall_s    = ~scl_filt_q &  scl_prev_q;
  // SDA edges only count as START/STOP while SCL is stably high.
  assign start_s       = scl_filt_q & scl_prev_q &  sda_prev_q & ~sda_filt_q;
  assign stop_s        = scl_filt_q & scl_prev_q & ~sda_prev_q &  sda_filt_q;

  assign byte_s        = {shift_q[6:0], sda_filt_q};
  assign ptr_inc_s     = ptr_q + 16'd1;
  assign ptr_idx_s     = ptr_q[MEM_AW-1:0];
  assign ptr_inc_idx_s = ptr_inc_s[MEM_AW-1:0];
  assign host_idx_s    = host_addr[MEM_AW-1:0];
  // Upper host address bits beyond the memory index are intentionally ignored.
  assign unused_host_hi_s = ^host_addr;

  assign sda_update_s  = hold_act_q & (hold_cnt_q == {HCW{1'b0}});

  assign host_rdata    = host_rdata_q;
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;

  // Filter next-state: a new level is accepted after FILTER_LEN equal samples.
  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = scl_cnt_q;
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = sda_cnt_q;
    if (scl_sync_q[1] == scl_filt_q) begin
      scl_cnt_d = {FCW{1'b0}};
    end else if (scl_cnt_q == FCW'(FILTER_LEN - 1)) begin
      scl_filt_d = scl_sync_q[1];
      scl_cnt_d  = {FCW{1'b0}};
    end else begin
      scl_cnt_d = scl_cnt_q + FCW'(1'b1);
    end
    if (sda_sync_q[1] == sda_filt_q) begin
      sda_cnt_d = {FCW{1'b0}};
    end else if (sda_cnt_q == FCW'(FILTER_LEN - 1)) begin
      sda_filt_d = sda_sync_q[1];
      sda_cnt_d  = {FCW{1'b0}};
    end else begin
      sda_cnt_d = sda_cnt_q + FCW'(1'b1);
    end
  end

  // Conditioning registers: synchronizers, filters and edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= {FCW{1'b0}};
      sda_cnt_q  <= {FCW{1'b0}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
    end
  end

  // Protocol next-state: SDA hold timer, SDA drive, byte FSM and pointer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    sda_low_d   = sda_low_q;
    hold_act_d  = hold_act_q;
    hold_cnt_d  = hold_cnt_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    i2c_we_s    = 1'b0;

    // SDA only changes SDA_HOLD clocks after a filtered SCL fall.
    if (scl_fall_s) begin
      hold_act_d = 1'b1;
      hold_cnt_d = HCW'(SDA_HOLD - 1);
    end else if (hold_act_q) begin
      if (hold_cnt_q == {HCW{1'b0}}) begin
        hold_act_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - HCW'(1'b1);
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    // What to put on SDA for the bit that follows this SCL low phase.
    if (sda_update_s) begin
      case (state_q)
        DEV_ACK, ADDR_HI_ACK, ADDR_LO_ACK, WR_ACK: sda_low_d = 1'b1;
        RD_DATA: sda_low_d = ~tx_q[3'd7 - bit_cnt_q];
        default: sda_low_d = 1'b0;
      endcase
    end else begin
      sda_low_d = sda_low_q;
    end

    if (start_s) begin
      // START or repeated START: re-address, pointer survives.
      state_d    = DEV_ADDR;
      bit_cnt_d  = 3'd0;
      sda_low_d  = 1'b0;
      hold_act_d = 1'b0;
    end else if (stop_s) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      busy_d     = 1'b0;
      sda_low_d  = 1'b0;
      hold_act_d = 1'b0;
    end else if (scl_rise_s) begin
      case (state_q)
        DEV_ADDR: begin
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_s[7:1] == dev_addr) begin
              busy_d  = 1'b1;
              state_d = DEV_ACK;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            state_d = DEV_ADDR;
          end
        end
        DEV_ACK: begin
          bit_cnt_d = 3'd0;
          if (shift_q[0]) begin
            tx_d    = mem_q[ptr_idx_s];
            state_d = RD_DATA;
          end else begin
            state_d = ADDR_HI;
          end
        end
        ADDR_HI: begin
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d[15:8] = byte_s;
            state_d     = ADDR_HI_ACK;
          end else begin
            state_d = ADDR_HI;
          end
        end
        ADDR_HI_ACK: begin
          bit_cnt_d = 3'd0;
          state_d   = ADDR_LO;
        end
        ADDR_LO: begin
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d[7:0] = byte_s;
            state_d    = ADDR_LO_ACK;
          end else begin
            state_d = ADDR_LO;
          end
        end
        ADDR_LO_ACK: begin
          bit_cnt_d = 3'd0;
          state_d   = WR_DATA;
        end
        WR_DATA: begin
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            i2c_we_s    = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            wr_data_d   = byte_s;
            state_d     = WR_ACK;
          end else begin
            state_d = WR_DATA;
          end
        end
        WR_ACK: begin
          bit_cnt_d = 3'd0;
          ptr_d     = ptr_inc_s;
          state_d   = WR_DATA;
        end
        RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RD_ACK;
          end else begin
            state_d = RD_DATA;
          end
        end
        RD_ACK: begin
          bit_cnt_d = 3'd0;
          ptr_d     = ptr_inc_s;
          if (!sda_filt_q) begin
            tx_d    = mem_q[ptr_inc_idx_s];
            state_d = RD_DATA;
          end else begin
            state_d = IGNORE;
          end
        end
        IDLE, IGNORE: state_d = state_q;
        default:      state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Protocol registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 16'h0000;
      tx_q        <= 8'h00;
      busy_q      <= 1'b0;
      sda_low_q   <= 1'b0;
      hold_act_q  <= 1'b0;
      hold_cnt_q  <= {HCW{1'b0}};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 16'h0000;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      sda_low_q   <= sda_low_d;
      hold_act_q  <= hold_act_d;
      hold_cnt_q  <= hold_cnt_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory write port: an I2C data byte takes priority over the host write.
  always_ff @(posedge clk) begin
    if (i2c_we_s && !rst) begin
      mem_q[ptr_idx_s] <= byte_s;
    end else if (host_we) begin
      mem_q[host_idx_s] <= host_wdata;
    end
  end

  // Host read port: registered, returns pre-write data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata_q <= 8'h00;
    end else begin
      host_rdata_q <= mem_q[host_idx_s];
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, scoreboarded wr_strobe
// and host read port, directed scenarios with hand-computed expectations.
module tb_i2c_target_regs;

  localparam int Q = 25;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  dev_addr;
  logic        scl;
  logic        m_low;
  logic [15:0] host_addr;
  logic        host_we;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  wire         sda_w;

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk        (clk),
    .rst        (rst),
    .dev_addr   (dev_addr),
    .i2c_scl    (scl),
    .i2c_sda    (sda_w),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [23:0] wr_q[$];   // {addr, data} expected per wr_strobe
  logic [7:0]  hq[$];     // expected host_rdata per issued read
  logic        hrd_v = 1'b0;
  logic        watch = 1'b0;
  logic        low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h required=%h", name, got, exp);
  endtask

  // Scoreboard monitor: wr_strobe pulses and host read results.
  always @(posedge clk) begin : mon
    logic        hv;
    logic [23:0] e;
    logic [7:0]  he;
    hv = hrd_v;
    #1;
    if (wr_strobe === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL wr_unexpected got addr=%h data=%h required no strobe", wr_addr, wr_data);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", {16'h0000, wr_addr}, {16'h0000, e[23:8]});
        check("wr_data", {24'h0, wr_data}, {24'h0, e[7:0]});
      end
    end
    if (hv) begin
      if (hq.size() == 0) begin
        chk_cnt++;
        $display("FAIL host_rd_queue got=%h required an expectation", host_rdata);
      end else begin
        he = hq.pop_front();
        check("host_rdata", {24'h0, host_rdata}, {24'h0, he});
      end
    end
  end

  // Watches for the target pulling SDA low while the master has released it.
  always @(negedge clk) begin
    if (watch && !m_low && sda_w === 1'b0) low_seen = 1'b1;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b1; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b0; wq(Q);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic smp);
    m_low = ~b; wq(Q); scl = 1'b1;
    if (glitch) begin
      wq(8); scl = 1'b0; wq(2); scl = 1'b1; wq(Q - 10);
    end else begin
      wq(Q);
    end
    smp = sda_w; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == gbit), s);
    clk_bit(1'b1, 1'b0, s);
    check({name, "_ack"}, {31'd0, s}, {31'd0, exp_ack});
  endtask

  task automatic recv_byte(input logic ack_bit, input logic [7:0] exp, input string name);
    logic [7:0] d;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(ack_bit, 1'b0, s);
    check(name, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic host_read(input logic [15:0] a, input logic [7:0] e);
    @(negedge clk);
    host_addr = a; hrd_v = 1'b1; hq.push_back(e);
    @(negedge clk);
    hrd_v = 1'b0;
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n;
    logic got;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; dev_addr = 7'h50;
    host_addr = 16'h0000; host_we = 1'b0; host_wdata = 8'h00;
    wq(3);
    @(posedge clk); #1;
    check("rst_sda", {31'd0, sda_w}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    @(negedge clk); rst = 1'b0;
    wq(30);

    // Host port: write/read, index wrap, same-cycle write returns old data.
    @(negedge clk); host_addr = 16'h0005; host_wdata = 8'h77; host_we = 1'b1;
    @(negedge clk); host_we = 1'b0;
    host_read(16'h0005, 8'h77);
    host_read(16'h0105, 8'h77);
    @(negedge clk); host_addr = 16'h0005; host_wdata = 8'h88; host_we = 1'b1;
    hrd_v = 1'b1; hq.push_back(8'h77);
    @(negedge clk); host_we = 1'b0; hq.push_back(8'h88);
    @(negedge clk); hrd_v = 1'b0;

    // Write 0x0010: A5 3C 7E.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "w_dev");
    send_byte(8'h00, -1, 1'b0, "w_ahi");
    send_byte(8'h10, -1, 1'b0, "w_alo");
    wr_q.push_back({16'h0010, 8'hA5});
    wr_q.push_back({16'h0011, 8'h3C});
    wr_q.push_back({16'h0012, 8'h7E});
    send_byte(8'hA5, -1, 1'b0, "w_d0");
    send_byte(8'h3C, -1, 1'b0, "w_d1");
    send_byte(8'h7E, -1, 1'b0, "w_d2");
    check("w_busy", {31'd0, busy}, 32'd1);
    i2c_stop(); wq(20);
    check("w_busy_stop", {31'd0, busy}, 32'd0);
    host_read(16'h0011, 8'h3C);

    // Random read with repeated START.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "r_dev");
    send_byte(8'h00, -1, 1'b0, "r_ahi");
    send_byte(8'h10, -1, 1'b0, "r_alo");
    i2c_start();
    send_byte(8'hA1, -1, 1'b0, "r_devr");
    recv_byte(1'b0, 8'hA5, "r_b0");
    recv_byte(1'b0, 8'h3C, "r_b1");
    recv_byte(1'b1, 8'h7E, "r_b2");
    check("r_sda_release", {31'd0, sda_w}, 32'd1);
    check("r_busy", {31'd0, busy}, 32'd1);
    i2c_stop(); wq(20);
    check("r_busy_stop", {31'd0, busy}, 32'd0);

    // Wrong device address: NACK, nothing driven, no writes.
    low_seen = 1'b0; watch = 1'b1;
    i2c_start();
    send_byte(8'hA2, -1, 1'b1, "n_dev");
    send_byte(8'h00, -1, 1'b1, "n_byte");
    check("n_busy", {31'd0, busy}, 32'd0);
    i2c_stop(); wq(20);
    watch = 1'b0;
    check("n_sda_driven", {31'd0, low_seen}, 32'd0);

    // Memory index wrap versus 16-bit pointer.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "x_dev");
    send_byte(8'h00, -1, 1'b0, "x_ahi");
    send_byte(8'hFF, -1, 1'b0, "x_alo");
    wr_q.push_back({16'h00FF, 8'h11});
    wr_q.push_back({16'h0100, 8'h22});
    send_byte(8'h11, -1, 1'b0, "x_d0");
    send_byte(8'h22, -1, 1'b0, "x_d1");
    i2c_stop(); wq(20);
    host_read(16'h00FF, 8'h11);
    host_read(16'h0000, 8'h22);

    // SCL glitch inside a data bit.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "g_dev");
    send_byte(8'h00, -1, 1'b0, "g_ahi");
    send_byte(8'h40, -1, 1'b0, "g_alo");
    wr_q.push_back({16'h0040, 8'hC3});
    send_byte(8'hC3, 4, 1'b0, "g_d0");
    i2c_stop(); wq(20);
    host_read(16'h0040, 8'hC3);

    // Collision: host write held through the I2C write edge.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "c_dev");
    send_byte(8'h00, -1, 1'b0, "c_ahi");
    send_byte(8'h20, -1, 1'b0, "c_alo");
    wr_q.push_back({16'h0020, 8'h99});
    fork
      send_byte(8'h99, -1, 1'b0, "c_d0");
      begin
        host_addr = 16'h0020; host_wdata = 8'h44; host_we = 1'b1;
        got = 1'b0;
        for (n = 0; n < 2000 && !got; n++) begin
          @(posedge clk); #1;
          got = wr_strobe;
        end
        host_we = 1'b0;
        if (!got) begin
          chk_cnt++;
          $display("FAIL c_strobe_wait got=timeout required=wr_strobe");
        end
      end
    join
    i2c_stop(); wq(20);
    host_read(16'h0020, 8'h99);

    // Reset in the middle of a read byte, then a clean transaction.
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "s_dev");
    send_byte(8'h00, -1, 1'b0, "s_ahi");
    send_byte(8'h11, -1, 1'b0, "s_alo");
    i2c_start();
    send_byte(8'hA1, -1, 1'b0, "s_devr");
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q / 2);
    check("s_drive_low", {31'd0, sda_w}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("s_rst_release", {31'd0, sda_w}, 32'd1);
    check("s_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    wq(Q); scl = 1'b0; wq(Q);
    i2c_start();
    send_byte(8'hA0, -1, 1'b0, "p_dev");
    send_byte(8'h00, -1, 1'b0, "p_ahi");
    send_byte(8'h30, -1, 1'b0, "p_alo");
    wr_q.push_back({16'h0030, 8'h5A});
    send_byte(8'h5A, -1, 1'b0, "p_d0");
    i2c_stop(); wq(20);
    host_read(16'h0030, 8'h5A);

    wq(10);
    check("wr_pending", wr_q.size(), 32'd0);
    check("host_pending", hq.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
